// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset-release controller.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro used by the top: RESET_SEQ_SW_REQ_EN.
package reset_seq_pkg;

  // Controller phases: all domains held, staged release, all released.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rseq_state_t;

  // Counter must hold the larger of the hold and gap terminal values.
  function automatic int rseq_cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rseq_counter.sv
// Loadable up-counter with terminal-count compare, shared by hold and gap phases.
// Latency: count updates one edge after enable; terminal flag is a compare on the current count.
// Backpressure: none; clear has priority over increment.
module rseq_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Clear to zero (reset or phase step), otherwise count while enabled.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staged reset release: holds all domains, releases them one by one, then flags ready.
// Latency: domain k releases HOLD_CYCLES + k*STAGE_GAP edges after reset/restart; ready after N_DOMAINS gaps more.
// Backpressure: sw_req is only honoured in RUN (macro RESET_SEQ_SW_REQ_EN); otherwise it is ignored.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4
) (
  input  logic                 i_clk_A,
  input  logic                 i_rst,
  input  logic                 i_sw_req,
  output logic                 o_sw_ack,
  output logic [N_DOMAINS-1:0] o_dom_rst_n,
  output logic                 o_ready
);

  localparam int CW = rseq_cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IW = $clog2(N_DOMAINS + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_END   = IW'(N_DOMAINS);

  rseq_state_t          r_state;
  logic [IW-1:0]        r_idx;
  logic [N_DOMAINS-1:0] r_dom_rst_n;
  logic                 r_ready;

  logic                 w_cnt_en;
  logic                 w_cnt_clr;
  logic [CW-1:0]        w_tc_val;
  logic                 w_tc;

`ifdef RESET_SEQ_SW_REQ_EN
  logic r_sw_pend;
  logic r_sw_ack;
  assign o_sw_ack = r_sw_ack;
`else
  logic w_unused_sw_req;
  assign w_unused_sw_req = i_sw_req;
  assign o_sw_ack        = 1'b0;
`endif

  // Counter runs in the hold/gap phases, restarts at each step, and sits at zero in RUN.
  always_comb begin
    w_cnt_en  = (r_state != RUN);
    w_tc_val  = (r_state == ASSERT) ? HOLD_LAST : GAP_LAST;
    w_cnt_clr = i_rst || (r_state == RUN) || (w_tc && w_cnt_en);
  end

  rseq_counter #(
    .W (CW)
  ) u_cnt (
    .i_clk    (i_clk_A),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_tc     (w_tc)
  );

  // Sequencing FSM; every output is a register updated here.
  always_ff @(posedge i_clk_A) begin
    if (i_rst) begin
      r_state     <= ASSERT;
      r_idx       <= '0;
      r_dom_rst_n <= '0;
      r_ready     <= 1'b0;
`ifdef RESET_SEQ_SW_REQ_EN
      r_sw_ack    <= 1'b0;
      r_sw_pend   <= 1'b0;
`endif
    end else begin
`ifdef RESET_SEQ_SW_REQ_EN
      r_sw_ack <= 1'b0;
`endif
      case (r_state)
        ASSERT: begin
          if (w_tc) begin
            r_dom_rst_n[0] <= 1'b1;
            r_idx          <= IW'(1);
            r_state        <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_tc) begin
            if (r_idx < IDX_END) begin
              for (int k = 0; k < N_DOMAINS; k++) begin
                if (r_idx == IW'(k)) begin
                  r_dom_rst_n[k] <= 1'b1;
                end
              end
              r_idx <= r_idx + IW'(1);
            end else begin
              r_state <= RUN;
              r_ready <= 1'b1;
`ifdef RESET_SEQ_SW_REQ_EN
              r_sw_ack  <= r_sw_pend;
              r_sw_pend <= 1'b0;
`endif
            end
          end
        end
        RUN: begin
`ifdef RESET_SEQ_SW_REQ_EN
          if (i_sw_req) begin
            r_state     <= ASSERT;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_ready     <= 1'b0;
            r_sw_pend   <= 1'b1;
          end
`endif
        end
        default: begin
          r_state     <= ASSERT;
          r_idx       <= '0;
          r_dom_rst_n <= '0;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign o_dom_rst_n = r_dom_rst_n;
  assign o_ready     = r_ready;

endmodule

// File: doc/reset_seq_ctrl.md
# reset_seq_ctrl

Staged reset-release controller sitting directly downstream of `reset_sync`. It takes the single synchronized reset of the `clk_A` domain and releases N downstream domain resets one at a time, with a fixed hold and a fixed gap between releases. It signals `ready` when all domains are out of reset, and accepts a software-requested re-sequence through a req/ack handshake.

## Interface
- `N_DOMAINS`, 4: number of sequenced domain resets; must be ≥1.
- `HOLD_CYCLES`, 8: edges all domains stay in reset after `rst` falls, before domain 0 releases; must be ≥1.
- `STAGE_GAP`, 4: edges between consecutive releases, and between the last release and `ready`; must be ≥1.
- `clk_A`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on `clk_A` only. This is the already-synchronized reset.
- `sw_req`  in  1  level request to re-run the full reset sequence.
- `sw_ack`  out  1  one-cycle pulse: software-initiated sequence finished.
- `dom_rst_n`  out  N_DOMAINS  active-low domain resets; bit k releases k-th.
- `ready`  out  1  high only while all domains are released and the FSM is in RUN.

## Operation
- FSM states: ASSERT, RELEASE, RUN.
- Internal counter `cnt`, width `$clog2(max(HOLD_CYCLES,STAGE_GAP)+1)`. Domain index `idx`, width `$clog2(N_DOMAINS+1)`.
- Internal flag `sw_pend` marks a software-initiated sequence.
- `rst`=1 at any edge, from any state:
  - next state ASSERT, `cnt`=0, `idx`=0;
  - `dom_rst_n`=all 0, `ready`=0, `sw_ack`=0, `sw_pend`=0.
- ASSERT:
  - `cnt` increments each edge.
  - When `cnt` reaches HOLD_CYCLES-1, that edge sets `dom_rst_n[0]`=1, `idx`=1, `cnt`=0, and moves to RELEASE.
- RELEASE:
  - `cnt` increments each edge.
  - At `cnt`=STAGE_GAP-1 with `idx`<N_DOMAINS: set `dom_rst_n[idx]`=1, `idx`++, `cnt`=0.
  - At `cnt`=STAGE_GAP-1 with `idx`=N_DOMAINS: go to RUN and set `ready`=1.
  - On the same edge, `sw_ack`=1 if `sw_pend` is set, and `sw_pend` clears.
- RUN:
  - `sw_req`=1 sampled: next state ASSERT, `dom_rst_n`=all 0, `ready`=0, `cnt`=0, `idx`=0, `sw_pend`=1.
- `sw_req` handshake:
  - Level-sensitive, sampled only in RUN; ignored in ASSERT and RELEASE.
  - The requester drops `sw_req` on the edge after it sees `sw_ack`.
  - If `sw_req` is still 1 in the cycle after `sw_ack`, a new sequence starts. This is legal and intended.
- Release order is strictly ascending. A released bit never returns to 0 except through ASSERT.
- If `rst` and `sw_req` are both high, `rst` wins and `sw_pend` stays 0, so no `sw_ack` is issued for that sequence.

## Timing
- Edge numbering: E1 is the first rising edge at which `rst`=0 is sampled. The same numbering applies after a `sw_req` edge.
- `dom_rst_n[k]` rises at edge E(HOLD_CYCLES + k·STAGE_GAP).
- `ready` (and `sw_ack`, if applicable) rises at edge E(HOLD_CYCLES + N_DOMAINS·STAGE_GAP).
- With defaults:
  - domain 0 releases at E8, domain 1 at E12, domain 2 at E16, domain 3 at E20;
  - `ready` rises at E24.
- `sw_req` sampled high in RUN: `ready`=0 and `dom_rst_n`=0 on the same edge.
- Reset mid-sequence: the sequence aborts on that edge, with no partial release retained.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `RESET_SEQ_SW_REQ_EN` defined: `sw_req`/`sw_ack` handshake and `sw_pend` logic present as above.
- Not defined:
  - `sw_req` is ignored and `sw_ack` is tied 0;
  - the sequence runs only after `rst`;
  - the ports remain in the port list so instantiations do not change.

## Structure
- Shared package `reset_seq_pkg`:
  - state typedef `rseq_state_t` (ASSERT, RELEASE, RUN);
  - localparam helper for counter width.
- One sub-module: `rseq_counter`, a loadable up-counter with terminal-count compare. It is instantiated once and shared by the hold and gap phases.

## Test plan
- Use a 20 ns clock. Hold `rst`=1 for 3 edges, then drop it → `dom_rst_n` = 0000 through E7; 0001 at E8, 0011 at E12, 0111 at E16, 1111 at E20; `ready`=1 at E24; `sw_ack` never pulses.
- In RUN, pulse `sw_req` for 1 cycle → same edge: `dom_rst_n`=0000, `ready`=0; full sequence repeats; `sw_ack` is a single-cycle pulse coincident with `ready` rising.
- Assert `rst` at E14 (`dom_rst_n`=0011) → next edge gives 0000; the sequence restarts from E1 after release, with no `sw_ack`.
- Hold `sw_req`=1 during ASSERT/RELEASE → no effect until RUN; then it triggers exactly one re-sequence.
- Keep `sw_req` high one cycle past `sw_ack` → second sequence starts immediately; `ready` high for exactly one cycle.
- Build without `RESET_SEQ_SW_REQ_EN` and toggle `sw_req` in RUN → `ready` stays 1, `dom_rst_n`=1111, `sw_ack`=0.
